// File: rtl/eth_tx_frame_gen_if.sv
// eth_tx_frame_gen_if: valid/ready byte stream from the frame generator into the MAC TX input
interface eth_tx_frame_gen_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;
    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/eth_tx_frame_gen.sv
// eth_tx_frame_gen: Ethernet II test-frame source (header, sequence number, pattern payload); define TXGEN_REPEAT_EN to add repeat_en for continuous frames
module eth_tx_frame_gen #(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int          PAYLOAD_LEN = 46,
    parameter int          GAP_CYCLES  = 24
) (
    input  logic               clk_mac,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         pattern,
`ifdef TXGEN_REPEAT_EN
    input  logic               repeat_en,
`endif
    output logic               busy,
    output logic [15:0]        frame_count,
    eth_tx_frame_gen_if.master tx
);
    localparam logic [111:0] HDR_BYTES = {DST_MAC, SRC_MAC, ETHERTYPE};
    localparam logic [10:0]  LAST      = 11'(14 + PAYLOAD_LEN - 1);
    localparam logic [15:0]  GAP_M1    = 16'(GAP_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, GAP} state_t;
    state_t      r_state, w_state;
    logic [10:0] r_idx, w_idx;
    logic [7:0]  r_pat, w_pat, r_data, w_data;
    logic        r_valid, w_valid, r_last, w_last, r_busy;
    logic [15:0] r_cnt, w_cnt, r_gap, w_gap;
    logic        w_acc, w_go, w_rep;
`ifdef TXGEN_REPEAT_EN
    assign w_rep = repeat_en;
`else
    assign w_rep = 1'b0;
`endif
    // Byte at frame position b: 14 header bytes MSB first, then sequence number, then pattern ramp
    function automatic logic [7:0] beat_byte(input logic [10:0] b, input logic [7:0] pat, input logic [15:0] cnt);
        return (b < 11'd14) ? HDR_BYTES[7'd111 - {b[3:0], 3'b000} -: 8] :
               (b == 11'd14) ? cnt[15:8] :
               (b == 11'd15) ? cnt[7:0] : pat + b[7:0] - 8'd16;
    endfunction
    // Next-state logic: advance the beat on accept, close the frame on tx_last, time the gap
    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_pat   = r_pat;
        w_data  = r_data;
        w_valid = r_valid;
        w_last  = r_last;
        w_cnt   = r_cnt;
        w_gap   = r_gap;
        w_acc   = r_valid && tx.tx_ready;
        w_go    = 1'b0;
        case (r_state)
            IDLE: w_go = start;
            HDR, PAYLOAD: begin
                if (w_acc && r_idx == LAST) begin
                    w_state = GAP;
                    w_valid = 1'b0;
                    w_last  = 1'b0;
                    w_data  = 8'h00;
                    w_cnt   = r_cnt + 16'd1;
                    w_gap   = 16'd0;
                end else if (w_acc) begin
                    w_idx   = r_idx + 11'd1;
                    w_data  = beat_byte(w_idx, r_pat, r_cnt);
                    w_last  = (w_idx == LAST);
                    w_state = (w_idx < 11'd14) ? HDR : PAYLOAD;
                end
            end
            GAP: begin
                w_gap = r_gap + 16'd1;
                if (r_gap == GAP_M1) begin
                    w_gap   = 16'd0;
                    w_state = IDLE;
                    w_go    = w_rep;
                end
            end
            default: w_state = IDLE;
        endcase
        if (w_go) begin
            w_state = HDR;
            w_idx   = 11'd0;
            w_pat   = pattern;
            w_data  = HDR_BYTES[111:104];
            w_valid = 1'b1;
            w_last  = 1'b0;
        end
    end
    // State and output registers; reset truncates any frame in flight
    always_ff @(posedge clk_mac) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= 11'd0;
            r_pat   <= 8'h00;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= 16'd0;
            r_gap   <= 16'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_pat   <= w_pat;
            r_data  <= w_data;
            r_valid <= w_valid;
            r_last  <= w_last;
            r_cnt   <= w_cnt;
            r_gap   <= w_gap;
            r_busy  <= (w_state != IDLE);
        end
    end
    assign tx.tx_data   = r_data;
    assign tx.tx_valid  = r_valid;
    assign tx.tx_last   = r_last;
    assign busy         = r_busy;
    assign frame_count  = r_cnt;
endmodule

// File: tb/tb_eth_tx_frame_gen.sv
// tb_eth_tx_frame_gen: directed bench for the Ethernet test-frame generator
module tb_eth_tx_frame_gen;
    logic        clk_mac = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  pattern = 8'h00;
    logic        busy;
    logic [15:0] frame_count;
`ifdef TXGEN_REPEAT_EN
    logic        repeat_en = 1'b0;
`endif
    eth_tx_frame_gen_if tx_if();
    eth_tx_frame_gen dut (
        .clk_mac(clk_mac),
        .rst(rst),
        .start(start),
        .pattern(pattern),
`ifdef TXGEN_REPEAT_EN
        .repeat_en(repeat_en),
`endif
        .busy(busy),
        .frame_count(frame_count),
        .tx(tx_if)
    );
    always #10 clk_mac = ~clk_mac;
    int total = 0;
    int bad = 0;
    logic [7:0] got_data [60];
    logic       got_last [60];
    int got_n, got_cyc, stall_bad, drop_bad, idle;
    bit timed_out;
    localparam logic [7:0] HDR [14] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                        8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h88, 8'hB5};
    function automatic logic [7:0] exp_byte(input int i, input logic [7:0] pat, input logic [15:0] cnt);
        if (i < 14) return HDR[i];
        if (i == 14) return cnt[15:8];
        if (i == 15) return cnt[7:0];
        return pat + 8'(i - 16);
    endfunction
    task automatic pulse_start(input logic [7:0] p);
        pattern = p;
        start = 1'b1;
        @(negedge clk_mac);
        start = 1'b0;
    endtask
    task automatic get_frame(input bit rnd, input int n);
        logic [7:0] hd = 8'h00;
        logic hl = 1'b0;
        bit held = 0;
        got_data = '{default: 8'hxx};
        got_last = '{default: 1'bx};
        got_n = 0; got_cyc = 0; stall_bad = 0; drop_bad = 0; timed_out = 0;
        while (got_n < n) begin
            tx_if.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held && tx_if.tx_valid && (tx_if.tx_data !== hd || tx_if.tx_last !== hl)) stall_bad++;
            if (got_n > 0 && !tx_if.tx_valid) drop_bad++;
            held = 0;
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                got_data[got_n] = tx_if.tx_data;
                got_last[got_n] = tx_if.tx_last;
                got_n++;
            end else if (tx_if.tx_valid) begin
                held = 1; hd = tx_if.tx_data; hl = tx_if.tx_last;
            end
            if (got_n < n) begin
                got_cyc++;
                if (got_cyc > 1000) begin timed_out = 1; break; end
                @(negedge clk_mac);
            end
        end
    endtask
    task automatic test_reset;
        repeat (3) @(negedge clk_mac);
        total++; if (tx_if.tx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", tx_if.tx_valid); end
        total++; if (tx_if.tx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", tx_if.tx_data); end
        total++; if (tx_if.tx_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", tx_if.tx_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%h exp=0000", frame_count); end
        rst = 1'b0;
        @(negedge clk_mac);
    endtask
    task automatic test_basic;
        pulse_start(8'h10);
        total++; if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== 8'hFF) begin bad++; $display("FAIL basic_latency got=%b/%h exp=1/ff", tx_if.tx_valid, tx_if.tx_data); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
        get_frame(0, 60);
        total++; if (got_n !== 60 || got_cyc !== 59) begin bad++; $display("FAIL basic_beats got=%0d/%0d cycles exp=60/59", got_n, got_cyc); end
        for (int i = 0; i < 60; i++) begin
            total++; if (got_data[i] !== exp_byte(i, 8'h10, 16'd0)) begin bad++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, got_data[i], exp_byte(i, 8'h10, 16'd0)); end
            total++; if (got_last[i] !== (i == 59)) begin bad++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, got_last[i], i == 59); end
        end
        @(negedge clk_mac);
        total++; if (tx_if.tx_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_gap got=%b/%b exp=0/1", tx_if.tx_valid, busy); end
        total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL basic_count got=%h exp=0001", frame_count); end
        repeat (30) @(negedge clk_mac);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b exp=0", busy); end
    endtask
    task automatic test_random_ready;
        pulse_start(8'h10);
        get_frame(1, 60);
        total++; if (got_n !== 60 || timed_out) begin bad++; $display("FAIL rand_beats got=%0d exp=60", got_n); end
        total++; if (stall_bad !== 0) begin bad++; $display("FAIL rand_stall_stable got=%0d exp=0", stall_bad); end
        total++; if (drop_bad !== 0) begin bad++; $display("FAIL rand_valid_drop got=%0d exp=0", drop_bad); end
        for (int i = 0; i < 60; i++) begin
            total++; if (got_data[i] !== exp_byte(i, 8'h10, 16'd1)) begin bad++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, got_data[i], exp_byte(i, 8'h10, 16'd1)); end
            total++; if (got_last[i] !== (i == 59)) begin bad++; $display("FAIL rand_last[%0d] got=%b exp=%b", i, got_last[i], i == 59); end
        end
        repeat (30) @(negedge clk_mac);
        total++; if (frame_count !== 16'd2) begin bad++; $display("FAIL rand_count got=%h exp=0002", frame_count); end
    endtask
    task automatic test_hold_start;
        rst = 1'b1;
        @(negedge clk_mac);
        rst = 1'b0;
        pulse_start(8'hF0);
        start = 1'b1;
        get_frame(0, 60);
        for (int i = 0; i < 60; i++) begin
            total++; if (got_data[i] !== exp_byte(i, 8'hF0, 16'd0)) begin bad++; $display("FAIL hold_f1_data[%0d] got=%h exp=%h", i, got_data[i], exp_byte(i, 8'hF0, 16'd0)); end
        end
        idle = 0;
        @(negedge clk_mac);
        while (!tx_if.tx_valid && idle < 100) begin idle++; @(negedge clk_mac); end
        total++; if (idle < 24 || idle >= 100) begin bad++; $display("FAIL hold_gap got=%0d exp=24..99", idle); end
        get_frame(0, 60);
        start = 1'b0;
        total++; if (got_n !== 60) begin bad++; $display("FAIL hold_f2_beats got=%0d exp=60", got_n); end
        for (int i = 0; i < 60; i++) begin
            total++; if (got_data[i] !== exp_byte(i, 8'hF0, 16'd1)) begin bad++; $display("FAIL hold_f2_data[%0d] got=%h exp=%h", i, got_data[i], exp_byte(i, 8'hF0, 16'd1)); end
            total++; if (got_last[i] !== (i == 59)) begin bad++; $display("FAIL hold_f2_last[%0d] got=%b exp=%b", i, got_last[i], i == 59); end
        end
        repeat (30) @(negedge clk_mac);
        total++; if (frame_count !== 16'd2 || busy !== 1'b0) begin bad++; $display("FAIL hold_end got=%h/%b exp=0002/0", frame_count, busy); end
    endtask
    task automatic test_reset_mid;
        pulse_start(8'h33);
        get_frame(0, 31);
        rst = 1'b1;
        @(negedge clk_mac);
        total++; if (tx_if.tx_valid !== 1'b0 || tx_if.tx_last !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b/%b exp=0/0", tx_if.tx_valid, tx_if.tx_last); end
        total++; if (busy !== 1'b0 || frame_count !== 16'd0) begin bad++; $display("FAIL midrst_state got=%b/%h exp=0/0000", busy, frame_count); end
        rst = 1'b0;
        @(negedge clk_mac);
        pulse_start(8'h55);
        get_frame(0, 60);
        total++; if (got_n !== 60) begin bad++; $display("FAIL midrst_beats got=%0d exp=60", got_n); end
        for (int i = 0; i < 60; i++) begin
            total++; if (got_data[i] !== exp_byte(i, 8'h55, 16'd0)) begin bad++; $display("FAIL midrst_data[%0d] got=%h exp=%h", i, got_data[i], exp_byte(i, 8'h55, 16'd0)); end
        end
        repeat (30) @(negedge clk_mac);
        total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL midrst_count got=%h exp=0001", frame_count); end
    endtask
    task automatic test_count_wrap;
        force dut.r_cnt = 16'hFFFF;
        repeat (2) @(negedge clk_mac);
        release dut.r_cnt;
        @(negedge clk_mac);
        total++; if (frame_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=ffff", frame_count); end
        pulse_start(8'h01);
        get_frame(0, 60);
        total++; if (got_data[14] !== 8'hFF || got_data[15] !== 8'hFF) begin bad++; $display("FAIL wrap_seq got=%h%h exp=ffff", got_data[14], got_data[15]); end
        total++; if (got_data[59] !== 8'h2C) begin bad++; $display("FAIL wrap_tail got=%h exp=2c", got_data[59]); end
        @(negedge clk_mac);
        total++; if (frame_count !== 16'h0000) begin bad++; $display("FAIL wrap_count got=%h exp=0000", frame_count); end
        repeat (30) @(negedge clk_mac);
    endtask
`ifdef TXGEN_REPEAT_EN
    task automatic test_repeat;
        repeat_en = 1'b1;
        pulse_start(8'h20);
        get_frame(0, 60);
        for (int i = 0; i < 60; i++) begin
            total++; if (got_data[i] !== exp_byte(i, 8'h20, 16'd0)) begin bad++; $display("FAIL rep_f1_data[%0d] got=%h exp=%h", i, got_data[i], exp_byte(i, 8'h20, 16'd0)); end
        end
        idle = 0;
        @(negedge clk_mac);
        while (!tx_if.tx_valid && idle < 100) begin idle++; @(negedge clk_mac); end
        total++; if (idle !== 24) begin bad++; $display("FAIL rep_gap got=%0d exp=24", idle); end
        get_frame(0, 60);
        repeat_en = 1'b0;
        for (int i = 0; i < 60; i++) begin
            total++; if (got_data[i] !== exp_byte(i, 8'h20, 16'd1)) begin bad++; $display("FAIL rep_f2_data[%0d] got=%h exp=%h", i, got_data[i], exp_byte(i, 8'h20, 16'd1)); end
        end
        idle = 0;
        @(negedge clk_mac);
        while (!tx_if.tx_valid && idle < 100) begin idle++; @(negedge clk_mac); end
        total++; if (idle !== 100 || busy !== 1'b0) begin bad++; $display("FAIL rep_stop got=%0d/%b exp=100/0", idle, busy); end
    endtask
`endif
    initial begin
        tx_if.tx_ready = 1'b1;
        @(negedge clk_mac);
        test_reset;
        test_basic;
        test_random_ready;
        test_hold_start;
        test_reset_mid;
        test_count_wrap;
`ifdef TXGEN_REPEAT_EN
        test_repeat;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
